// File: rtl/spi_master_multi.sv
// spi_master_multi: parameterised SPI master with per-transfer CPOL/CPHA and bit order,
// driving one of NUM_SS active-low slave selects.
module spi_master_multi #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_SS  = 2,
    parameter int SEL_W   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic [SEL_W-1:0]  i_ss_sel,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_lsb_first,
    input  logic              i_miso,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_mosi,
    output logic              o_sck,
    output logic [NUM_SS-1:0] o_ss
);
    localparam int HALF_W = $clog2(2 * DATA_W);
    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;
    state_t r_state, w_state_nxt;
    logic [7:0]        r_div;
    logic [HALF_W-1:0] r_half;
    logic [DATA_W-1:0] r_tx, r_rx;
    logic              r_cpol, r_cpha, r_lsb;
    logic              w_div_end, w_half_last, w_edge, w_lead_edge, w_shift, w_sample;
    logic [NUM_SS-1:0] w_ss_dec;

    function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d >> 1 : d << 1;
    endfunction

    always_comb begin
        w_div_end   = r_div == 8'(CLK_DIV - 1);
        w_half_last = r_half == HALF_W'(2 * DATA_W - 1);
        // an SCK edge opens every half-period; the LEAD->XFER edge is the first leading edge
        w_edge      = w_div_end && (r_state == LEAD || (r_state == XFER && !w_half_last));
        w_lead_edge = w_edge && (r_state == LEAD || r_half[0]);
        w_shift     = r_cpha ? w_lead_edge
                             : (w_edge && !w_lead_edge && r_half != HALF_W'(2 * DATA_W - 2));
        w_sample    = w_edge && (w_lead_edge != r_cpha);
        for (int k = 0; k < NUM_SS; k++) w_ss_dec[k] = i_ss_sel != SEL_W'(k);
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = i_start ? LEAD : IDLE;
            LEAD:    w_state_nxt = w_div_end ? XFER : LEAD;
            XFER:    w_state_nxt = (w_div_end && w_half_last) ? TRAIL : XFER;
            TRAIL:   w_state_nxt = w_div_end ? DONE : TRAIL;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) r_state <= reset ? IDLE : w_state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div     <= '0;
            r_half    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_rx_data <= '0;
            o_mosi    <= 1'b0;
            o_sck     <= 1'b0;
            o_ss      <= '1;
        end else begin
            o_done <= 1'b0;
            r_div  <= (r_state == IDLE || w_div_end) ? '0 : r_div + 8'd1;
            if (r_state == IDLE) begin
                o_sck <= i_cpol;
                if (i_start) begin
                    // CPHA=0 presents the first bit before any SCK edge
                    r_tx   <= i_cpha ? i_tx_data : next_word(i_tx_data, i_lsb_first);
                    o_mosi <= i_cpha ? o_mosi : first_bit(i_tx_data, i_lsb_first);
                    r_cpol <= i_cpol;
                    r_cpha <= i_cpha;
                    r_lsb  <= i_lsb_first;
                    o_ss   <= w_ss_dec;
                    o_busy <= 1'b1;
                end
            end
            if (w_edge) begin
                o_sck  <= ~o_sck;
                r_half <= (r_state == LEAD) ? '0 : r_half + 1'b1;
            end
            if (w_shift) begin
                o_mosi <= first_bit(r_tx, r_lsb);
                r_tx   <= next_word(r_tx, r_lsb);
            end
            if (w_sample) r_rx <= r_lsb ? {i_miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], i_miso};
            if (r_state == XFER && w_div_end && w_half_last) o_sck <= r_cpol;
            if (r_state == TRAIL && w_div_end) begin
                o_ss      <= '1;
                o_done    <= 1'b1;
                o_rx_data <= r_rx;
            end
            if (r_state == DONE) o_busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: loopback bench with a serial slave monitor and an rx/latency scoreboard.
module tb_spi_master_multi;
    logic       clk = 1'b0;
    logic       reset;
    logic       i_start, i_cpol, i_cpha, i_lsb_first, i_miso;
    logic [7:0] i_tx_data;
    logic [1:0] i_ss_sel;
    logic       o_busy, o_done, o_mosi, o_sck;
    logic [7:0] o_rx_data;
    logic [1:0] o_ss;

    spi_master_multi #(.DATA_W(8), .CLK_DIV(2), .NUM_SS(2), .SEL_W(2)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_tx_data(i_tx_data),
        .i_ss_sel(i_ss_sel), .i_cpol(i_cpol), .i_cpha(i_cpha), .i_lsb_first(i_lsb_first),
        .i_miso(i_miso), .o_busy(o_busy), .o_done(o_done), .o_rx_data(o_rx_data),
        .o_mosi(o_mosi), .o_sck(o_sck), .o_ss(o_ss)
    );

    assign i_miso = o_mosi;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic       cpol, cpha, lsb;
        logic [1:0] sel;
        logic [7:0] exp_rx;
        logic       exp_first;
        logic [1:0] exp_ss;
    } vec_t;

    vec_t       vecs[8];
    int         checks = 0, failures = 0;
    int         cyc = 0, done_cnt = 0;
    logic [7:0] sb_q[$];
    int         acc_q[$];
    int         rise_cnt = 0, nbits = 0, unstable = 0, gap, d0;
    logic [1:0] ss_and, ss_or;
    logic [7:0] slave_word, exp_rx;
    logic       first_seen, cur_cpol, cur_cpha, cur_lsb, prev_sck, prev_mosi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // serial slave model and scoreboard: sample MOSI on the mode's sampling edge
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            acc_q.delete();
        end else begin
            if (i_start && !o_busy) begin
                acc_q.push_back(cyc);
                rise_cnt = 0; nbits = 0; unstable = 0;
                ss_and = '1; ss_or = '0; slave_word = '0;
                cur_cpol = i_cpol; cur_cpha = i_cpha; cur_lsb = i_lsb_first;
            end
            if (o_busy && !o_done) begin
                ss_and &= o_ss;
                ss_or  |= o_ss;
            end
            if (o_busy && o_sck != prev_sck) begin
                if (o_sck) rise_cnt++;
                if ((o_sck != cur_cpol) != cur_cpha) begin
                    if (o_mosi != prev_mosi) unstable++;
                    if (nbits == 0) first_seen = o_mosi;
                    slave_word = cur_lsb ? {o_mosi, slave_word[7:1]} : {slave_word[6:0], o_mosi};
                    nbits++;
                end
            end
            if (o_done) begin
                done_cnt++;
                if (sb_q.size() == 0 || acc_q.size() == 0) chk("unexpected_done", o_done, 0);
                else begin
                    exp_rx = sb_q.pop_front();
                    chk("rx_data", o_rx_data, exp_rx);
                    chk("latency", cyc - acc_q.pop_front(), 37);
                end
            end
        end
        prev_sck  = o_sck;
        prev_mosi = o_mosi;
    end

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_done && n < 200);
        if (!o_done) chk("done_timeout", o_done, 1);
    endtask

    task automatic xfer(input logic [7:0] tx, input logic cpol, cpha, lsb,
                        input logic [1:0] sel, input logic [7:0] rx);
        @(posedge clk); #1;
        i_tx_data = tx; i_cpol = cpol; i_cpha = cpha; i_lsb_first = lsb; i_ss_sel = sel;
        repeat (3) @(posedge clk);
        #1;
        chk("sck_idle_pre", o_sck, cpol);
        i_start = 1'b1;
        sb_q.push_back(rx);
        @(posedge clk); #1;
        i_start = 1'b0;
        i_tx_data = ~tx; i_cpha = ~cpha; i_lsb_first = ~lsb; i_ss_sel = ~sel;
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; i_start = 1'b0; i_tx_data = '0; i_ss_sel = '0;
        i_cpol = 1'b0; i_cpha = 1'b0; i_lsb_first = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_values", {o_busy, o_done, o_rx_data, o_mosi, o_sck, o_ss}, {2'b00, 8'h00, 2'b00, 2'b11});
        reset = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 8'hA5, 1'b1, 2'b10};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 2'd0, 8'h3C, 1'b0, 2'b10};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 2'd0, 8'h3C, 1'b0, 2'b10};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 2'd0, 8'h3C, 1'b0, 2'b10};
        vecs[4] = '{8'h01, 1'b0, 1'b0, 1'b1, 2'd0, 8'h01, 1'b1, 2'b10};
        vecs[5] = '{8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0, 2'b10};
        vecs[6] = '{8'h96, 1'b1, 1'b1, 1'b1, 2'd1, 8'h96, 1'b0, 2'b01};
        vecs[7] = '{8'hC3, 1'b0, 1'b1, 1'b0, 2'd3, 8'hC3, 1'b1, 2'b11};

        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i].tx, vecs[i].cpol, vecs[i].cpha, vecs[i].lsb, vecs[i].sel, vecs[i].exp_rx);
            chk("slave_word", slave_word, vecs[i].tx);
            chk("first_mosi_bit", first_seen, vecs[i].exp_first);
            chk("sck_rises", rise_cnt, 8);
            chk("ss_pattern", {ss_and, ss_or}, {vecs[i].exp_ss, vecs[i].exp_ss});
            chk("mosi_unstable", unstable, 0);
            repeat (2) @(posedge clk);
            #1;
            chk("sck_idle_post", o_sck, vecs[i].cpol);
        end

        // back-to-back with i_start held high; tx changes right after the first accept
        @(posedge clk); #1;
        i_tx_data = 8'hF0; i_cpol = 1'b0; i_cpha = 1'b0; i_lsb_first = 1'b0; i_ss_sel = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        d0 = done_cnt;
        i_start = 1'b1;
        sb_q.push_back(8'hF0);
        @(posedge clk); #1;
        i_tx_data = 8'h0F;
        sb_q.push_back(8'h0F);
        wait_done();
        gap = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_ss[1]) gap++;
            else break;
        end
        chk("ss_gap", gap, 1);
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done();
        repeat (45) @(posedge clk);
        chk("b2b_dones", done_cnt - d0, 2);

        // reset in the middle of XFER, after three bits, in mode 2 so SCK idles high
        @(posedge clk); #1;
        i_tx_data = 8'hAA; i_cpol = 1'b1; i_cpha = 1'b0; i_lsb_first = 1'b0; i_ss_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        d0 = done_cnt;
        i_start = 1'b1;
        sb_q.push_back(8'hAA);
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("pre_reset_busy", o_busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_values", {o_busy, o_done, o_rx_data, o_mosi, o_sck, o_ss}, {2'b00, 8'h00, 2'b00, 2'b11});
        reset = 1'b0;
        repeat (45) @(posedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        xfer(8'h5A, 1'b0, 1'b0, 1'b0, 2'd0, 8'h5A);

        // out-of-range select, with start pulses while busy and in the done cycle
        @(posedge clk); #1;
        i_tx_data = 8'h66; i_cpol = 1'b0; i_cpha = 1'b0; i_lsb_first = 1'b0; i_ss_sel = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        d0 = done_cnt;
        i_start = 1'b1;
        sb_q.push_back(8'h66);
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (50) @(posedge clk);
        chk("oor_one_done", done_cnt - d0, 1);
        chk("oor_ss", {ss_and, ss_or}, 4'b1111);

        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
- Parametrised successor to the team's single-mode 8-bit SPI master.
- Configurable word width and SCK divider; selects one of NUM_SS active-low slave selects.
- All four SPI modes (CPOL/CPHA) and MSB/LSB-first order, chosen per transfer.
- Sits between a local controller (start/done handshake) and the off-chip SPI pins.

Parameters:
- DATA_W, 8: bits per transfer word; legal range 2..32.
- CLK_DIV, 4: clk cycles per SCK half-period; legal range 1..255.
- NUM_SS, 2: number of slave-select outputs; legal range 1..8.
- SEL_W, 1: width of i_ss_sel; must be at least 1 and cover NUM_SS-1.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  request a transfer; accepted only while o_busy=0.
- i_tx_data  in  DATA_W  word to send; latched on accept.
- i_ss_sel  in  SEL_W  slave index; latched on accept.
- i_cpol  in  1  SCK idle level; latched on accept.
- i_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accept.
- i_lsb_first  in  1  bit order, 1 = LSB first; latched on accept.
- i_miso  in  1  serial data from slave.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle pulse at end of transfer.
- o_rx_data  out  DATA_W  received word; valid from the o_done cycle and held until the next o_done.
- o_mosi  out  1  serial data to slave.
- o_sck  out  1  SPI clock.
- o_ss  out  NUM_SS  active-low slave selects.

Behaviour:
- Clocking and reset: one clock. Synchronous active-high reset.
- Reset values: o_busy=0, o_done=0, o_rx_data=0, o_mosi=0, o_sck=0, o_ss=all ones. State goes to IDLE.
- Reset mid-transfer: abort within one edge and apply the reset values. There is no done pulse and o_rx_data is cleared.
- States: IDLE -> LEAD -> XFER -> TRAIL -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - o_sck tracks i_cpol, registered each cycle, so the line settles before a transfer.
  - If i_start=1, latch tx data, sel, cpol, cpha and lsb_first, then go to LEAD.
- LEAD (CLK_DIV cycles):
  - o_ss[sel]=0 and o_busy=1.
  - CPHA=0: o_mosi carries the first bit from LEAD entry.
  - CPHA=1: o_mosi holds its previous value.
- XFER (2*DATA_W half-periods, CLK_DIV cycles each):
  - o_sck toggles at the start of each half-period; the first toggle is the leading edge.
  - CPHA=0: sample i_miso on each leading edge; shift the next bit onto o_mosi on each trailing edge except the last.
  - CPHA=1: shift a bit onto o_mosi on each leading edge; sample on each trailing edge.
  - Bit order: bit DATA_W-1 first, or bit 0 first when lsb_first=1. Received bits are assembled in the same order, so loopback returns tx data unchanged.
- TRAIL (CLK_DIV cycles): o_sck = cpol and o_ss is still asserted.
- DONE (1 cycle):
  - o_ss = all ones, o_done=1, o_rx_data updated, o_busy=1.
  - Next cycle returns to IDLE.
- Latency: o_done rises exactly CLK_DIV*(2*DATA_W+2)+1 cycles after the cycle in which i_start is sampled high. Example: DATA_W=8, CLK_DIV=2 gives 37.
- Back-to-back transfers:
  - The earliest new accept is the cycle after o_done, so o_ss stays deasserted for at least 1 cycle between transfers.
  - i_start is ignored while o_busy=1, including the o_done cycle. No queuing.
- Input stability: changes to i_tx_data or mode inputs after accept have no effect on the transfer in progress.
- Out-of-range select (i_ss_sel >= NUM_SS):
  - The transfer runs with full timing and the done pulse.
  - No o_ss bit asserts.
  - o_rx_data captures i_miso as usual.
- CLK_DIV=1: SCK = clk/2, and every timing rule above still holds.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=2, sel 0, MISO looped to MOSI, tx 0xA5 -> o_done 37 cycles after start, o_rx_data=0xA5, exactly 8 rising SCK edges, only o_ss[0] low during the transfer.
- Modes 1, 2 and 3 with tx 0x3C, loopback, and a slave model checking the sample edge -> rx 0x3C each time; SCK idles at cpol before and after; MOSI is stable at each sampling edge.
- lsb_first=1, tx 0x01, slave model captures serial order -> the first MOSI bit is 1; loopback rx=0x01; with lsb_first=0 the first bit is 0.
- Back-to-back: i_start held high through two transfers (0xF0 then 0x0F), sel 1 -> second accept the cycle after o_done; o_ss[1] high exactly 1 cycle between; rx 0xF0 then 0x0F.
- Reset asserted mid-XFER (after 3 bits) -> next edge o_ss=all ones, o_sck=0, o_busy=0, o_rx_data=0, no o_done; a new transfer of 0x5A then completes with rx 0x5A.
- i_ss_sel=3 with NUM_SS=2 -> o_ss stays all ones, o_done still pulses at 37 cycles; i_start pulses during busy are ignored (exactly one o_done).
